// File: rtl/zram_arbiter.sv
// Two-port arbiter/sequencer for the shared 16x8 zephyr RAM: one access per 3 cycles.
// Build option: define ZRAM_ARB_RR_EN for round-robin tie breaking (default: port 0 wins ties).
module zram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              R0_REQ,
  input  logic              R0_WE,
  input  logic [ADDR_W-1:0] R0_ADDR,
  input  logic [DATA_W-1:0] R0_WDATA,
  output logic              R0_ACK,
  output logic [DATA_W-1:0] R0_RDATA,
  input  logic              R1_REQ,
  input  logic              R1_WE,
  input  logic [ADDR_W-1:0] R1_ADDR,
  input  logic [DATA_W-1:0] R1_WDATA,
  output logic              R1_ACK,
  output logic [DATA_W-1:0] R1_RDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_OP,
  output logic [DATA_W-1:0] RAM_DATA_IN,
  input  logic [DATA_W-1:0] RAM_DATA_OUT,
  output logic              BUSY,
  output logic              OWNER
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ram_addr, ram_addr_nxt;
  logic              ram_op, ram_op_nxt;
  logic [DATA_W-1:0] ram_din, ram_din_nxt;
  logic              ack0, ack0_nxt;
  logic              ack1, ack1_nxt;
  logic [DATA_W-1:0] rdata0, rdata0_nxt;
  logic [DATA_W-1:0] rdata1, rdata1_nxt;
  logic              busy, busy_nxt;
  logic              owner, owner_nxt;
  logic              last, last_nxt;
  logic              winner;

  always_comb begin
    winner       = 1'b0;
    state_nxt    = state;
    ram_addr_nxt = ram_addr;
    ram_op_nxt   = ram_op;
    ram_din_nxt  = ram_din;
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    rdata0_nxt   = rdata0;
    rdata1_nxt   = rdata1;
    owner_nxt    = owner;
    last_nxt     = last;

`ifdef ZRAM_ARB_RR_EN
    winner = (R0_REQ && R1_REQ) ? ~last : R1_REQ;
`else
    winner = ~R0_REQ;
`endif

    case (state)
      IDLE: begin
        if (R0_REQ || R1_REQ) begin
          owner_nxt    = winner;
          ram_addr_nxt = winner ? R1_ADDR  : R0_ADDR;
          ram_din_nxt  = winner ? R1_WDATA : R0_WDATA;
          ram_op_nxt   = winner ? R1_WE    : R0_WE;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        // RAM has had a full cycle of stable address/op; capture its read port now.
        ram_op_nxt = 1'b0;
        if (!ram_op) begin
          if (owner) rdata1_nxt = RAM_DATA_OUT;
          else       rdata0_nxt = RAM_DATA_OUT;
        end
        if (owner) ack1_nxt = 1'b1;
        else       ack0_nxt = 1'b1;
        last_nxt  = owner;
        state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        ram_op_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      ram_addr <= '0;
      ram_op   <= 1'b0;
      ram_din  <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      busy     <= 1'b0;
      owner    <= 1'b0;
      last     <= 1'b1;
    end else begin
      state    <= state_nxt;
      ram_addr <= ram_addr_nxt;
      ram_op   <= ram_op_nxt;
      ram_din  <= ram_din_nxt;
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
      rdata0   <= rdata0_nxt;
      rdata1   <= rdata1_nxt;
      busy     <= busy_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
    end
  end

  assign RAM_ADDR    = ram_addr;
  assign RAM_OP      = ram_op;
  assign RAM_DATA_IN = ram_din;
  assign R0_ACK      = ack0;
  assign R1_ACK      = ack1;
  assign R0_RDATA    = rdata0;
  assign R1_RDATA    = rdata1;
  assign BUSY        = busy;
  assign OWNER       = owner;

  // The priority pointer always names the port whose access is being acknowledged.
  a_last_tracks_owner: assert property (@(posedge CLK) disable iff (RESET)
    (state == ACK) |-> (last == owner));

  a_write_pulse_single: assert property (@(posedge CLK) disable iff (RESET)
    ram_op |=> !ram_op);

endmodule

// File: tb/tb_zram_arbiter.sv
// Bench for zram_arbiter: directed cycle table, tie sequences, and a randomized
// run against a transaction-timestamp reference model with a behavioural RAM.
`timescale 1ns/1ps
module tb_zram_arbiter;

  localparam logic [7:0] INIT [16] = '{8'h5A, 8'h5B, 8'h11, 8'h77, 8'h5E, 8'h5F, 8'h5C, 8'h5D,
                                       8'h52, 8'h99, 8'h50, 8'h51, 8'h56, 8'h57, 8'h54, 8'h55};

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       q [2];
  logic       w [2];
  logic [3:0] a [2];
  logic [7:0] d [2];
  logic       r0_ack, r1_ack, ram_op, busy, owner;
  logic [7:0] r0_rdata, r1_rdata, ram_din, ram_dout;
  logic [3:0] ram_addr;
  logic [7:0] mem [16] = INIT;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  assign ram_dout = mem[ram_addr];
  always @(posedge CLK) if (ram_op) mem[ram_addr] <= ram_din;

  zram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .R0_REQ(q[0]), .R0_WE(w[0]), .R0_ADDR(a[0]), .R0_WDATA(d[0]),
    .R0_ACK(r0_ack), .R0_RDATA(r0_rdata),
    .R1_REQ(q[1]), .R1_WE(w[1]), .R1_ADDR(a[1]), .R1_WDATA(d[1]),
    .R1_ACK(r1_ack), .R1_RDATA(r1_rdata),
    .RAM_ADDR(ram_addr), .RAM_OP(ram_op), .RAM_DATA_IN(ram_din), .RAM_DATA_OUT(ram_dout),
    .BUSY(busy), .OWNER(owner)
  );

  typedef struct {
    int rst, q0, w0, a0, d0, q1, w1, a1, d1;
    int eb, eo, ea0, ea1, eop, er0, er1;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input int rst, q0, w0, a0, d0, q1, w1, a1, d1,
                              input int eb, eo, ea0, ea1, eop, er0, er1);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eb = eb; v.eo = eo; v.ea0 = ea0; v.ea1 = ea1; v.eop = eop; v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    RESET = 1'(v.rst);
    q[0] = 1'(v.q0); w[0] = 1'(v.w0); a[0] = 4'(v.a0); d[0] = 8'(v.d0);
    q[1] = 1'(v.q1); w[1] = 1'(v.w1); a[1] = 4'(v.a1); d[1] = 8'(v.d1);
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      q[p] = 1'b0; w[p] = 1'b0; a[p] = 4'd0; d[p] = 8'd0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1'b1;
    idle_inputs();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Reference model state for the randomized run
  logic [7:0] ref_mem [16];
  logic [7:0] exp_rd [2];
  int         k, next_free, g_edge;
  logic       have, g_port, g_we, last_w, win;
  logic [3:0] g_addr;
  logic [7:0] g_rd;
  logic       e_busy, e_op, e_ack0, e_ack1, e_own;
  int         seq [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    //        rst q0 w0 a0 d0     q1 w1 a1 d1      bsy own a0 a1 op rd0    rd1
    tbl[0]  = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,      0, 0, 0, 0, 0, 'h00, 'h00);
    tbl[1]  = mk(0, 0, 0, 0, 0,     1, 1, 5, 'hA5,   1, 1, 0, 0, 1, 'h00, 'h00);
    tbl[2]  = mk(0, 0, 0, 0, 0,     1, 1, 5, 'hA5,   1, 1, 0, 1, 0, 'h00, 'h00);
    tbl[3]  = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,      0, 1, 0, 0, 0, 'h00, 'h00);
    tbl[4]  = mk(0, 1, 0, 5, 0,     0, 0, 0, 0,      1, 0, 0, 0, 0, 'h00, 'h00);
    tbl[5]  = mk(0, 1, 0, 5, 0,     0, 0, 0, 0,      1, 0, 1, 0, 0, 'hA5, 'h00);
    tbl[6]  = mk(0, 1, 0, 2, 0,     0, 0, 0, 0,      0, 0, 0, 0, 0, 'hA5, 'h00);
    tbl[7]  = mk(0, 1, 0, 2, 0,     0, 0, 0, 0,      1, 0, 0, 0, 0, 'hA5, 'h00);
    tbl[8]  = mk(0, 1, 0, 2, 0,     0, 0, 0, 0,      1, 0, 1, 0, 0, 'h11, 'h00);
    tbl[9]  = mk(0, 1, 0, 9, 0,     0, 0, 0, 0,      0, 0, 0, 0, 0, 'h11, 'h00);
    tbl[10] = mk(0, 1, 0, 9, 0,     0, 0, 0, 0,      1, 0, 0, 0, 0, 'h11, 'h00);
    tbl[11] = mk(0, 1, 0, 9, 0,     0, 0, 0, 0,      1, 0, 1, 0, 0, 'h99, 'h00);
    tbl[12] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,      0, 0, 0, 0, 0, 'h99, 'h00);
    tbl[13] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,      0, 0, 0, 0, 0, 'h99, 'h00);
    tbl[14] = mk(0, 1, 1, 3, 'h3C,  0, 0, 0, 0,      1, 0, 0, 0, 1, 'h99, 'h00);
    tbl[15] = mk(1, 1, 1, 3, 'h3C,  0, 0, 0, 0,      0, 0, 0, 0, 0, 'h00, 'h00);
    tbl[16] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,      0, 0, 0, 0, 0, 'h00, 'h00);
    tbl[17] = mk(0, 1, 0, 3, 0,     0, 0, 0, 0,      1, 0, 0, 0, 0, 'h00, 'h00);
    tbl[18] = mk(0, 1, 0, 3, 0,     0, 0, 0, 0,      1, 0, 1, 0, 0, 'h77, 'h00);
    tbl[19] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,      0, 0, 0, 0, 0, 'h77, 'h00);
    tbl[20] = mk(0, 0, 0, 0, 0,     1, 0, 9, 0,      1, 1, 0, 0, 0, 'h77, 'h00);
    tbl[21] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,      1, 1, 0, 1, 0, 'h77, 'h99);
    tbl[22] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0,      0, 1, 0, 0, 0, 'h77, 'h99);

    // Reset state while RESET is held
    repeat (3) @(negedge CLK);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_op", ram_op, 1'b0);
    chk1("rst_ack0", r0_ack, 1'b0);
    chk1("rst_ack1", r1_ack, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk8("rst_addr", 8'(ram_addr), 8'h00);
    chk8("rst_din", ram_din, 8'h00);
    chk8("rst_rd0", r0_rdata, 8'h00);
    chk8("rst_rd1", r1_rdata, 8'h00);

    for (int i = 0; i < 23; i++) begin
      @(negedge CLK);
      apply(tbl[i]);
      @(posedge CLK);
      #1;
      chk1($sformatf("tbl%0d_busy", i), busy, 1'(tbl[i].eb));
      chk1($sformatf("tbl%0d_owner", i), owner, 1'(tbl[i].eo));
      chk1($sformatf("tbl%0d_ack0", i), r0_ack, 1'(tbl[i].ea0));
      chk1($sformatf("tbl%0d_ack1", i), r1_ack, 1'(tbl[i].ea1));
      chk1($sformatf("tbl%0d_op", i), ram_op, 1'(tbl[i].eop));
      chk8($sformatf("tbl%0d_rd0", i), r0_rdata, 8'(tbl[i].er0));
      chk8($sformatf("tbl%0d_rd1", i), r1_rdata, 8'(tbl[i].er1));
    end

    // Both ports hammer reads continuously from a fresh reset
    pulse_reset();
    q[0] = 1'b1; w[0] = 1'b0; a[0] = 4'd2;
    q[1] = 1'b1; w[1] = 1'b0; a[1] = 4'd9;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #1;
      if (r0_ack) begin
        seq.push_back(0);
        chk8("tie_rd0", r0_rdata, 8'h11);
      end
      if (r1_ack) begin
        seq.push_back(1);
        chk8("tie_rd1", r1_rdata, 8'h99);
      end
    end
    chk8("tie_ack_count", 8'(seq.size()), 8'd4);
    for (int i = 0; i < seq.size(); i++) begin
`ifdef ZRAM_ARB_RR_EN
      chk1($sformatf("tie_order%0d", i), 1'(seq[i]), 1'(i % 2));
`else
      chk1($sformatf("tie_order%0d", i), 1'(seq[i]), 1'b0);
`endif
    end

    // Randomized traffic against the timestamp model
    pulse_reset();
    ref_mem = INIT;
    ref_mem[5] = 8'hA5;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    k = 0;
    next_free = 1;
    have = 1'b0;
    last_w = 1'b1;
    g_edge = 0; g_port = 1'b0; g_we = 1'b0; g_addr = 4'd0; g_rd = 8'd0;
    for (int it = 0; it < 400; it++) begin
      @(posedge CLK);
      k++;
      #1;
      if (k >= next_free && (q[0] || q[1])) begin
`ifdef ZRAM_ARB_RR_EN
        win = (q[0] && q[1]) ? !last_w : q[1];
`else
        win = q[0] ? 1'b0 : 1'b1;
`endif
        have = 1'b1; g_edge = k; g_port = win; last_w = win;
        g_we = w[win]; g_addr = a[win];
        if (g_we) ref_mem[g_addr] = d[win];
        else      g_rd = ref_mem[g_addr];
        next_free = k + 3;
      end
      e_busy = have && (k - g_edge <= 1);
      e_op   = have && g_we && (k == g_edge);
      e_ack0 = have && (k == g_edge + 1) && !g_port;
      e_ack1 = have && (k == g_edge + 1) && g_port;
      e_own  = have ? g_port : 1'b0;
      if (have && (k == g_edge + 1) && !g_we) exp_rd[g_port] = g_rd;
      chk1("rnd_busy", busy, e_busy);
      chk1("rnd_op", ram_op, e_op);
      chk1("rnd_ack0", r0_ack, e_ack0);
      chk1("rnd_ack1", r1_ack, e_ack1);
      chk1("rnd_owner", owner, e_own);
      chk8("rnd_rd0", r0_rdata, exp_rd[0]);
      chk8("rnd_rd1", r1_rdata, exp_rd[1]);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && e_ack0) || (p == 1 && e_ack1)) begin
          q[p] = 1'($urandom_range(0, 1));
          w[p] = 1'($urandom_range(0, 1));
          a[p] = 4'($urandom_range(0, 15));
          d[p] = 8'($urandom);
        end else if (!q[p] && $urandom_range(0, 2) == 0) begin
          q[p] = 1'b1;
          w[p] = 1'($urandom_range(0, 1));
          a[p] = 4'($urandom_range(0, 15));
          d[p] = 8'($urandom);
        end
      end
    end

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
